// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    StBoot    = 3'd0,
    StIssue   = 3'd1,
    StWait    = 3'd2,
    StKill    = 3'd3,
    StDeliver = 3'd4
  } pcgen_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator and fetch sequencer: one outstanding fetch, squashes
// fetches made stale by a redirect, and holds the delivered PC while decode stalls.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fetch_req_o,
  output logic [ADDR_WIDTH-1:0] fetch_pc_o,
  input  logic                  fetch_ready_i,
  input  logic                  fetch_done_i,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  input  logic                  id_stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_target_i
);

  pcgen_state_t          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  if_valid_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;

  logic [ADDR_WIDTH-1:0] tgt;
  logic [ADDR_WIDTH-1:0] pc_inc;

  // Word-align the redirect target and form the sequential successor (wraps naturally).
  always_comb begin
    tgt    = {redirect_target_i[ADDR_WIDTH-1:2], 2'b00};
    pc_inc = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  end

  // Sequencer state, PC bookkeeping and registered decode handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q <= StIssue;
        end
        StIssue: begin
          if (redirect_i) begin
            pc_q <= tgt;
            // An accepted request in the redirect cycle is already stale.
            if (fetch_ready_i) state_q <= StKill;
          end else if (fetch_ready_i) begin
            inflight_pc_q <= pc_q;
            pc_q          <= pc_inc;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (redirect_i) begin
            pc_q    <= tgt;
            state_q <= fetch_done_i ? StIssue : StKill;
          end else if (fetch_done_i) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= inflight_pc_q;
            state_q    <= StDeliver;
          end
        end
        StKill: begin
          if (redirect_i) pc_q <= tgt;
          if (fetch_done_i) state_q <= StIssue;
        end
        StDeliver: begin
          if (redirect_i) begin
            pc_q       <= tgt;
            if_valid_q <= 1'b0;
            state_q    <= StIssue;
          end else if (!id_stall_i) begin
            if_valid_q <= 1'b0;
            state_q    <= StIssue;
          end
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

  // Request outputs decoded purely from registered state.
  always_comb begin
    fetch_req_o = (state_q == StIssue);
    fetch_pc_o  = pc_q;
    if_valid_o  = if_valid_q;
    if_pc_o     = if_pc_q;
  end

endmodule
